// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline sequencing controller.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam logic [1:0] CAUSE_ECALL  = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;

  typedef enum logic [2:0] {
    RUN          = 3'd0,
    DRAIN_FENCE  = 3'd1,
    DRAIN_ECALL  = 3'd2,
    DRAIN_EBREAK = 3'd3,
    TRAP         = 3'd4,
    HALT         = 3'd5
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the ID sources and a load in EX.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_reg_write_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  output logic              load_use_c_o
);

  logic ex_load_c;
  logic src_match_c;

  assign ex_load_c   = ex_valid_i && ex_mem_read_i && ex_reg_write_i && (ex_rd_addr_i != REG_ZERO);
  assign src_match_c = (id_uses_rs1_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_uses_rs2_i && (id_rs2_addr_i == ex_rd_addr_i));
  assign load_use_c_o = id_valid_i && ex_load_c && src_match_c;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble/flush sequencing with FENCE/ECALL/EBREAK drain FSM.
// Optional saturating stall/flush counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN_CNT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_ecall,
  input  logic              id_ebreak,
  input  logic              id_fence,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_redirect,
  input  logic              mem_valid,
  input  logic              wb_valid,
  input  logic              resume,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if,
  output logic              trap_req,
  output logic              halted
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [XLEN_CNT-1:0] stall_cnt,
  output logic [XLEN_CNT-1:0] flush_cnt
`endif
);

  state_e state_q, state_d;
  logic   trap_req_q, halted_q;
  logic   load_use_c, occupied_c;
  logic   stall_c, bubble_c, flush_c;

  hazard_detect u_hazard_detect (
    .id_valid_i     (id_valid),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_uses_rs1_i  (id_uses_rs1),
    .id_uses_rs2_i  (id_uses_rs2),
    .ex_valid_i     (ex_valid),
    .ex_mem_read_i  (ex_mem_read),
    .ex_reg_write_i (ex_reg_write),
    .ex_rd_addr_i   (ex_rd_addr),
    .load_use_c_o   (load_use_c)
  );

  assign occupied_c = ex_valid || mem_valid || wb_valid;

  // Next-state and strobe decode; redirect pre-empts everything except resume.
  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (load_use_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (id_valid) begin
          if (id_ebreak)     state_d = DRAIN_EBREAK;
          else if (id_ecall) state_d = DRAIN_ECALL;
          else if (id_fence) state_d = DRAIN_FENCE;
        end
      end
      DRAIN_FENCE, DRAIN_ECALL, DRAIN_EBREAK: begin
        if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = RUN;
        end else if (occupied_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else begin
          unique case (state_q)
            DRAIN_ECALL:  state_d = TRAP;
            DRAIN_EBREAK: state_d = HALT;
            default:      state_d = RUN;
          endcase
        end
      end
      TRAP: begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        state_d  = RUN;
      end
      HALT: begin
        // On resume the held ebreak is bubbled rather than re-decoded.
        if (resume) begin
          bubble_c = 1'b1;
          state_d  = RUN;
        end else if (ex_redirect) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = RUN;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign stall_if  = stall_c  && rst_n;
  assign stall_id  = stall_c  && rst_n;
  assign bubble_ex = bubble_c && rst_n;
  assign flush_if  = flush_c  && rst_n;
  assign trap_req  = trap_req_q;
  assign halted    = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      trap_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      trap_req_q <= (state_d == TRAP);
      halted_q   <= (state_d == HALT);
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [XLEN_CNT-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + XLEN_CNT'(1);
      if (flush_if && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + XLEN_CNT'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (counters checked with PIPE_HAZARD_PERF_EN).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_ecall, id_ebreak, id_fence;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       ex_valid, ex_mem_read, ex_reg_write, ex_redirect, mem_valid, wb_valid, resume;
  logic       stall_if, stall_id, bubble_ex, flush_if, trap_req, halted;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, flush_before;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN_CNT(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ecall(id_ecall), .id_ebreak(id_ebreak), .id_fence(id_fence),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .resume(resume),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .trap_req(trap_req), .halted(halted)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stall_if, stall_id, bubble_ex, flush_if packed as one 4-bit vector
  function automatic logic [31:0] strobes();
    return {28'd0, stall_if, stall_id, bubble_ex, flush_if};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_ecall = 0; id_ebreak = 0; id_fence = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_redirect = 0;
    mem_valid = 0; wb_valid = 0; resume = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    ex_redirect = 1;
    #2;
    chk("reset_strobes", strobes(), 4'b0000);
    chk("reset_trap", {31'd0, trap_req}, 0);
    chk("reset_halted", {31'd0, halted}, 0);
    tick();
    ex_redirect = 0;
    rst_n = 1;
`ifdef PIPE_HAZARD_PERF_EN
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
`endif
    tick();

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID
    id_valid = 1; id_uses_rs1 = 1; id_uses_rs2 = 1; id_rs1_addr = 5; id_rs2_addr = 1;
    ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 5;
    #2 chk("loaduse_stall", strobes(), 4'b1110);
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd_addr = 0;
    #2 chk("loaduse_release", strobes(), 4'b0000);

    // x0 destination never stalls
    ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 0; id_rs1_addr = 0;
    #2 chk("zero_reg_guard", strobes(), 4'b0000);
    // rs2 match but rs2 not read
    ex_rd_addr = 7; id_rs1_addr = 1; id_rs2_addr = 7; id_uses_rs2 = 0;
    #2 chk("rs2_unused_guard", strobes(), 4'b0000);
    id_uses_rs2 = 1;
    #2 chk("rs2_match_stall", strobes(), 4'b1110);
    ex_reg_write = 0;
    #2 chk("no_regwrite_guard", strobes(), 4'b0000);
    // Redirect beats load-use
    ex_reg_write = 1; ex_redirect = 1;
    #2 chk("redirect_over_loaduse", strobes(), 4'b0011);
    tick();
    idle_inputs();

    // FENCE drain with ex/mem/wb emptying one per cycle
    id_valid = 1; id_fence = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    #2 chk("fence_entry_no_stall", strobes(), 4'b0000);
    tick();
    id_valid = 0; id_fence = 0;
    #2 chk("fence_drain_c1", strobes(), 4'b1110);
    tick(); ex_valid = 0;
    #2 chk("fence_drain_c2", strobes(), 4'b1110);
    tick(); mem_valid = 0;
    #2 chk("fence_drain_c3", strobes(), 4'b1110);
    tick(); wb_valid = 0;
    #2 chk("fence_drain_done", strobes(), 4'b0000);
    tick();
    ex_valid = 1;
    #2 chk("fence_back_to_run", strobes(), 4'b0000);
    chk("fence_trap", {31'd0, trap_req}, 0);
    chk("fence_halted", {31'd0, halted}, 0);
    idle_inputs();
    tick();

    // ECALL with empty pipeline
    id_valid = 1; id_ecall = 1;
    tick();
    idle_inputs();
    #2 chk("ecall_drain_strobes", strobes(), 4'b0000);
    chk("ecall_drain_trap", {31'd0, trap_req}, 0);
    tick();
    chk("ecall_trap_pulse", {31'd0, trap_req}, 1);
    chk("ecall_trap_strobes", strobes(), 4'b0011);
    tick();
    chk("ecall_trap_end", {31'd0, trap_req}, 0);
    chk("ecall_after_strobes", strobes(), 4'b0000);

    // ecall+fence together: ecall wins, ends in a trap
    id_valid = 1; id_ecall = 1; id_fence = 1;
    tick();
    idle_inputs();
    tick();
    chk("prio_ecall_over_fence", {31'd0, trap_req}, 1);
    tick();

    // EBREAK (with ecall/fence also set), hold 10 cycles, resume
    id_valid = 1; id_ebreak = 1; id_ecall = 1; id_fence = 1;
    tick();
    chk("ebreak_drain_halted", {31'd0, halted}, 0);
    tick();
    chk("ebreak_halted", {31'd0, halted}, 1);
    chk("ebreak_no_trap", {31'd0, trap_req}, 0);
    for (int i = 0; i < 10; i++) begin
      chk("halt_hold", {30'd0, halted, stall_if}, 2'b11);
      tick();
    end
    resume = 1;
    #2 chk("resume_strobes", strobes(), 4'b0010);
    tick();
    idle_inputs();
    chk("resume_halted", {31'd0, halted}, 0);
    ex_valid = 1;
    #2 chk("resume_in_run", strobes(), 4'b0000);
    idle_inputs();
    tick();

    // Redirect during DRAIN_FENCE
    id_valid = 1; id_fence = 1; ex_valid = 1; mem_valid = 1; wb_valid = 1;
    tick();
    id_valid = 0; id_fence = 0;
    #2 chk("drain_before_redirect", strobes(), 4'b1110);
`ifdef PIPE_HAZARD_PERF_EN
    flush_before = flush_cnt;
`endif
    ex_redirect = 1;
    #2 chk("drain_redirect", strobes(), 4'b0011);
    tick();
    ex_redirect = 0;
    #2 chk("redirect_back_to_run", strobes(), 4'b0000);
`ifdef PIPE_HAZARD_PERF_EN
    chk("flush_cnt_inc", flush_cnt, flush_before + 1);
`endif
    idle_inputs();
    tick();

    // Async reset while halted
    id_valid = 1; id_ebreak = 1;
    tick(); tick();
    chk("halt_before_reset", {31'd0, halted}, 1);
    #2 rst_n = 0;
    #1 chk("async_reset_halted", {31'd0, halted}, 0);
    idle_inputs();
    tick();
    rst_n = 1;
    ex_valid = 1;
    #2 chk("after_reset_run", strobes(), 4'b0000);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It takes decode-stage control bits (register addresses, ecall/ebreak/fence) and downstream occupancy. It produces IF/ID stall, bubble-insert and flush strobes. It detects load-use hazards, applies branch/jump redirect flushes, and runs a drain state machine that serialises FENCE, ECALL and EBREAK.

## Interface
Parameters:
- XLEN_CNT, 32, width of optional performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a valid instruction
- id_rs1_addr, id_rs2_addr  in  5  decoded source registers
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_ecall, id_ebreak, id_fence  in  1  decoded system/fence flags
- ex_valid, ex_mem_read, ex_reg_write  in  1  EX-stage instruction flags
- ex_rd_addr  in  5  EX-stage destination
- ex_redirect  in  1  taken branch / JAL / JALR resolved in EX
- mem_valid, wb_valid  in  1  MEM/WB occupancy
- resume  in  1  leave HALT
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID instruction
- bubble_ex  out  1  load NOP into ID/EX
- flush_if  out  1  kill IF/ID contents
- trap_req  out  1  one-cycle ECALL trap pulse (registered)
- halted  out  1  core halted by EBREAK (registered)
- stall_cnt, flush_cnt  out  XLEN_CNT  only with PIPE_HAZARD_PERF_EN

## Operation
- States: RUN, DRAIN_FENCE, DRAIN_ECALL, DRAIN_EBREAK, TRAP, HALT.
- Redirect has top priority in every state. If ex_redirect=1, then flush_if=1 and bubble_ex=1, and the ID instruction is cancelled. A DRAIN_* state that was entered from a wrong-path instruction returns to RUN.
- Load-use stall in RUN applies when all of the following hold:
  - id_valid, ex_valid, ex_mem_read and ex_reg_write are all 1
  - ex_rd_addr≠0
  - ex_rd_addr matches (id_uses_rs1 & id_rs1_addr) or (id_uses_rs2 & id_rs2_addr)
  - Response: stall_if=stall_id=bubble_ex=1 for exactly one cycle.
- RUN transitions: when id_valid, there is no redirect and there is no load-use stall:
  - id_fence → DRAIN_FENCE
  - id_ecall → DRAIN_ECALL
  - id_ebreak → DRAIN_EBREAK
  - If several flags are set, priority is ebreak > ecall > fence.
- DRAIN_*: stall_if=stall_id=bubble_ex=1 while any of ex_valid/mem_valid/wb_valid is 1. When all three are 0:
  - DRAIN_FENCE → RUN; the fence retires as a NOP.
  - DRAIN_ECALL → TRAP.
  - DRAIN_EBREAK → HALT.
- TRAP: trap_req=1 for one cycle, flush_if=1, bubble_ex=1, then → RUN.
- HALT: halted=1; stall_if=stall_id=bubble_ex=1. resume=1 → RUN next cycle, and the ebreak in ID is bubbled (not re-executed).

## Timing
- stall_if/stall_id/bubble_ex/flush_if are combinational from the current state and inputs. They are valid in the same cycle.
- trap_req and halted are registered from the next-state logic.
- State, trap_req, halted and the counters all have reset value 0 / RUN. The combinational outputs are 0 under reset.
- Reset asserted mid-drain or in HALT returns to RUN immediately (async).
- Load-use penalty: 1 cycle. Redirect penalty: 2 instructions flushed (IF/ID and ID/EX).
- Drain latency: 0–3 cycles, depending on occupancy. Entry into DRAIN takes 1 cycle after the ID flags are seen.
- Simultaneous redirect and resume in HALT is impossible, because EX is empty; resume wins.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - stall_cnt increments every cycle stall_if=1.
  - flush_cnt increments every cycle flush_if=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: the counter ports and registers are absent, and the behaviour is otherwise identical.

## Structure
- The shared package pipe_pkg holds:
  - the state enum (RUN…HALT, 3 bits)
  - the trap cause constants (CAUSE_ECALL=2'd0, CAUSE_EBREAK=2'd1)
  - localparam REG_ZERO=5'd0
- Sub-module: hazard_detect, which implements the combinational load-use compare. The FSM and counters stay in the top.

## Test plan
- Load-use stall:
  - Stimulus: LW x5 in EX (ex_mem_read=1, ex_rd_addr=5), ADD x6,x5,x1 in ID.
  - Response: stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then 0.
- Zero-register guard:
  - Stimulus: same as load-use, but ex_rd_addr=0, or the match is on rs2 with id_uses_rs2=0.
  - Response: no stall.
- FENCE drain:
  - Stimulus: FENCE in ID with ex/mem/wb valid=1,1,1, dropping one per cycle.
  - Response: stall held for 3 cycles, then back to RUN. trap_req and halted stay 0.
- ECALL:
  - Stimulus: ECALL in ID with an empty pipeline.
  - Response: 1 drain cycle, then trap_req=1 for exactly one cycle with flush_if=1.
- EBREAK then resume:
  - Stimulus: EBREAK, wait 10 cycles, then pulse resume=1.
  - Response: halted=1 throughout the wait; the next cycle halted=0, state RUN.
- Redirect during DRAIN_FENCE:
  - Stimulus: ex_redirect=1 while in DRAIN_FENCE.
  - Response: flush_if=bubble_ex=1 and return to RUN. With PIPE_HAZARD_PERF_EN, flush_cnt increments by 1.
